// File: rtl/serial_add_pkg.sv
// ----------------------------------------------------------------------------
// serial_add_pkg
// Shared constants for the bit-serial adder controller: FSM state encoding
// and the default operand width of the 4-bit CPU datapath.
// ----------------------------------------------------------------------------
package serial_add_pkg;

    // Default operand / sum width
    localparam int unsigned SERIAL_ADD_DEFAULT_WIDTH = 4;

    // Control FSM state encoding
    localparam int unsigned ST_W = 2;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage : serial_add_pkg

// File: rtl/serial_add_seq_full_adder.sv
// ----------------------------------------------------------------------------
// serial_add_seq_full_adder
// Single-bit full-adder cell, time-shared by serial_add_seq across all
// operand bits.
//
// Ports:
//   a, b  - operand bits
//   cin   - carry in
//   s     - sum bit
//   cout  - carry out
// ----------------------------------------------------------------------------
module serial_add_seq_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    always_comb begin
        s    = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule : serial_add_seq_full_adder

// File: rtl/serial_add_seq.sv
// ----------------------------------------------------------------------------
// serial_add_seq
// Multi-cycle bit-serial adder. On an accepted start the operands are latched
// into shift registers and a single full-adder cell is stepped LSB-first, one
// bit per clock, with the carry held in a flop between bits. After WIDTH bit
// cycles the sum and carry-out are published and o_done pulses for one cycle.
//
// Optional feature (macro SERIAL_ADD_SUB_EN): adds the i_sub port; an accepted
// i_sub=1 computes A-B by loading ~B and forcing the carry-in to 1, so
// o_cout=1 means "no borrow".
//
// Ports:
//   i_clk    - clock, rising edge
//   i_rst    - asynchronous active-high reset
//   i_start  - operation request, honoured only when idle
//   i_a/i_b  - operands, captured with an accepted start
//   i_cin    - carry-in, captured with an accepted start
//   i_sub    - subtract select (only with SERIAL_ADD_SUB_EN)
//   o_busy   - high while an operation is in progress (incl. DONE cycle)
//   o_done   - one-cycle result-valid pulse
//   o_sum    - result, held until the next completed operation
//   o_cout   - final carry-out, held with o_sum
// ----------------------------------------------------------------------------
module serial_add_seq
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = SERIAL_ADD_DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             i_sub,
`endif
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    // Registered state
    logic [ST_W-1:0]  state_q,  state_d;
    logic [WIDTH-1:0] a_sh_q,   a_sh_d;
    logic [WIDTH-1:0] b_sh_q,   b_sh_d;
    // Only the WIDTH-1 already-computed bits are stored; the newest bit comes
    // straight from the cell, so the completed sum is {fa_s, sum_sh_q}.
    logic [WIDTH-2:0] sum_sh_q, sum_sh_d;
    logic             carry_q,  carry_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic             busy_d;
    logic             done_d;

    // Shared bit cell
    logic             fa_s;
    logic             fa_cout;
    logic [WIDTH-1:0] sum_full;

    // Operand B and carry-in as seen at load time (subtract folds in here)
    logic [WIDTH-1:0] b_load;
    logic             cin_load;

    serial_add_seq_full_adder u_fa (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    assign sum_full = {fa_s, sum_sh_q};

    // Load-time operand conditioning
`ifdef SERIAL_ADD_SUB_EN
    always_comb begin
        b_load   = i_sub ? ~i_b : i_b;
        cin_load = i_sub ? 1'b1 : i_cin;
    end
`else
    always_comb begin
        b_load   = i_b;
        cin_load = i_cin;
    end
`endif

    // Next-state and datapath control
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sum_d    = o_sum;
        cout_d   = o_cout;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    a_sh_d   = i_a;
                    b_sh_d   = b_load;
                    carry_d  = cin_load;
                    sum_sh_d = '0;
                    cnt_d    = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                carry_d  = fa_cout;
                sum_sh_d = sum_full[WIDTH-1:1];
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    // Last bit: publish the completed result on this edge
                    sum_d   = sum_full;
                    cout_d  = fa_cout;
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status outputs are registered from the next state
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            o_sum    <= '0;
            o_cout   <= 1'b0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            o_sum    <= sum_d;
            o_cout   <= cout_d;
            o_busy   <= busy_d;
            o_done   <= done_d;
        end
    end

endmodule : serial_add_seq

// File: tb/tb_serial_add_seq.sv
// ----------------------------------------------------------------------------
// tb_serial_add_seq
// Directed bench for serial_add_seq (WIDTH=4). Expected results are pushed to
// a scoreboard queue at issue time; a monitor pops and compares on o_done.
// ----------------------------------------------------------------------------
module tb_serial_add_seq;

    localparam int WIDTH = 4;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        int               cyc;
    } exp_t;

    logic             i_clk = 1'b0;
    logic             i_rst = 1'b1;
    logic             i_start = 1'b0;
    logic [WIDTH-1:0] i_a = '0;
    logic [WIDTH-1:0] i_b = '0;
    logic             i_cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    logic             i_sub = 1'b0;
`endif
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_sum;
    logic             o_cout;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    exp_t sb_q[$];

    serial_add_seq #(.WIDTH(WIDTH)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (i_start),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_cin   (i_cin),
`ifdef SERIAL_ADD_SUB_EN
        .i_sub   (i_sub),
`endif
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_sum   (o_sum),
        .o_cout  (o_cout)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    function automatic void check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: every done pulse must match the oldest outstanding request
    always @(negedge i_clk) begin
        if (o_done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sum", int'(o_sum), int'(e.sum));
                check("cout", int'(o_cout), int'(e.cout));
                check("done_cycle", cyc, e.cyc);
            end
        end
    end

    // Issue one request at the current negedge and follow it to completion.
    // inject=1 raises a second start (a=1,b=1) mid-RUN, which must be ignored.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic cin, input logic [WIDTH-1:0] es,
                          input logic ec, input bit inject);
        exp_t e;
        int   n;
        e.sum  = es;
        e.cout = ec;
        e.cyc  = cyc + 1 + WIDTH;
        sb_q.push_back(e);
        i_start = 1'b1;
        i_a     = a;
        i_b     = b;
        i_cin   = cin;
        @(negedge i_clk);
        i_start = 1'b0;
        i_a     = WIDTH'($urandom);
        i_b     = WIDTH'($urandom);
        i_cin   = 1'($urandom);
        n = 0;
        while (o_busy && n < 20) begin
            n++;
            if (inject && n == 2) begin
                i_start = 1'b1;
                i_a     = WIDTH'(1);
                i_b     = WIDTH'(1);
            end else begin
                i_start = 1'b0;
            end
            @(negedge i_clk);
        end
        i_start = 1'b0;
        check("busy_cycles", n, WIDTH + 1);
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_busy", int'(o_busy), 0);
        check("rst_done", int'(o_done), 0);
        check("rst_sum",  int'(o_sum),  0);
        check("rst_cout", int'(o_cout), 0);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);

        // Basic add, then results must hold through idle with changing inputs
        run_op(4'd3, 4'd5, 1'b0, 4'd8, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            i_a = WIDTH'($urandom);
            i_b = WIDTH'($urandom);
            @(negedge i_clk);
            check("hold_sum",  int'(o_sum),  8);
            check("hold_cout", int'(o_cout), 0);
        end

        // Carry boundary cases
        run_op(4'd15, 4'd1,  1'b0, 4'd0,  1'b1, 1'b0);
        run_op(4'd15, 4'd15, 1'b1, 4'd15, 1'b1, 1'b0);

        // Start during RUN ignored; next start right after DONE accepted
        run_op(4'd3, 4'd5, 1'b0, 4'd8, 1'b0, 1'b1);
        run_op(4'd15, 4'd15, 1'b1, 4'd15, 1'b1, 1'b0);

        // Reset in the second RUN cycle aborts with no done
        i_start = 1'b1;
        i_a     = 4'd7;
        i_b     = 4'd7;
        i_cin   = 1'b0;
        @(negedge i_clk);
        i_start = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b1;
        #1;
        check("abort_busy", int'(o_busy), 0);
        check("abort_done", int'(o_done), 0);
        check("abort_sum",  int'(o_sum),  0);
        check("abort_cout", int'(o_cout), 0);
        @(negedge i_clk);
        i_rst = 1'b0;
        repeat (8) @(negedge i_clk);
        check("abort_idle_busy", int'(o_busy), 0);
        check("abort_idle_sum",  int'(o_sum),  0);
        run_op(4'd2, 4'd2, 1'b0, 4'd4, 1'b0, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
        // Subtract: cout=1 means no borrow; i_cin is overridden
        i_sub = 1'b1;
        run_op(4'd5, 4'd3, 1'b0, 4'd2,  1'b1, 1'b0);
        run_op(4'd3, 4'd5, 1'b0, 4'd14, 1'b0, 1'b0);
        i_sub = 1'b0;
        run_op(4'd5, 4'd3, 1'b0, 4'd8,  1'b0, 1'b0);
`endif

        // Drain the scoreboard
        for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge i_clk);
        check("scoreboard_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_serial_add_seq
